// File: rtl/mem_request_queue_pkg.sv
// Shared types and constants for the memory request queue slice.
package mem_request_queue_pkg;

  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned QUEUE_DEPTH   = 16;

  typedef logic [31:0] int_t;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } parsed_op_t;

  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    int_t                     time_cpu;
    logic                     op_ready_s;
  } parser_out_struct_t;

  typedef struct packed {
    parsed_op_t               opcode;
    logic [ADDRESS_WIDTH-1:0] address;
    int_t                     time_cpu;
    int_t                     time_enq;
  } queue_entry_t;

endpackage

// File: rtl/mem_request_queue_if.sv
// Parser/scheduler-facing bundle of the request queue.
interface mem_request_queue_if
  import mem_request_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = mem_request_queue_pkg::QUEUE_DEPTH,
  parameter int unsigned TIME_WIDTH  = 32
);
  parser_out_struct_t            in;
  logic [TIME_WIDTH-1:0]         queue_time;
  logic                          queue_full;
  logic                          pending_request;
  logic                          head_valid;
  queue_entry_t                  head;
  logic                          head_pop;
  logic [$clog2(QUEUE_DEPTH):0]  occupancy;

  // Parser and scheduler side
  modport master (
    output in, head_pop,
    input  queue_time, queue_full, pending_request, head_valid, head, occupancy
  );

  // Queue side
  modport slave (
    input  in, head_pop,
    output queue_time, queue_full, pending_request, head_valid, head, occupancy
  );
endinterface

// File: rtl/mem_request_queue_circ_buffer.sv
// Generic circular buffer: storage, read/write pointers and occupancy.
// Caller guarantees push only when not full (or with a simultaneous pop)
// and pop only when not empty.
module circ_buffer #(
  parameter int unsigned DEPTH   = 16,
  parameter type         entry_t = logic
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wr_data,
  output entry_t                   rd_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_MAX = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           mem [DEPTH];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
    end
  end

  // Entry storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Occupancy sanity check
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (occupancy <= OCC_MAX)
        else $fatal(1, "circ_buffer occupancy exceeds depth");
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (occupancy == OCC_MAX);
  assign empty   = (occupancy == '0);
endmodule

// File: rtl/mem_request_queue.sv
// In-order request queue between trace parser and DRAM scheduler.
// Owns the simulation time base; accepts a request once its CPU time is reached.
module mem_request_queue
  import mem_request_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = mem_request_queue_pkg::QUEUE_DEPTH,
  parameter int unsigned TIME_WIDTH  = 32
) (
  input logic                clk,
  input logic                rst_n,
  mem_request_queue_if.slave bus
);
  logic                          valid_in;
  logic                          time_reached;
  logic                          pop_eff;
  logic                          push;
  logic                          full;
  logic                          empty;
  logic [TIME_WIDTH-1:0]         queue_time;
  logic [TIME_WIDTH-1:0]         req_time;
  logic [$clog2(QUEUE_DEPTH):0]  occupancy;
  queue_entry_t                  wr_entry;
  queue_entry_t                  rd_entry;

  // Accept rule and parser handshake
  always_comb begin
    req_time     = TIME_WIDTH'(bus.in.time_cpu);
    valid_in     = bus.in.op_ready_s && (bus.in.opcode != NOP);
    time_reached = (req_time <= queue_time);
    pop_eff      = bus.head_pop && !empty;
    // A full queue still accepts when the head retires on the same edge.
    push         = valid_in && time_reached && (!full || pop_eff);
    wr_entry     = '{opcode:   bus.in.opcode,
                     address:  bus.in.address,
                     time_cpu: bus.in.time_cpu,
                     time_enq: int_t'(queue_time)};
  end

  // Time base: advance one CPU clock, or skip ahead when idle and the next request is in the future
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queue_time <= '0;
    end else if (empty && valid_in && !time_reached) begin
      queue_time <= req_time;
    end else begin
      queue_time <= queue_time + 1'b1;
    end
  end

  circ_buffer #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (queue_entry_t)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop_eff),
    .wr_data   (wr_entry),
    .rd_data   (rd_entry),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  assign bus.queue_time      = queue_time;
  assign bus.queue_full      = full;
  assign bus.pending_request = valid_in && !push;
  assign bus.head_valid      = !empty;
  assign bus.head            = rd_entry;
  assign bus.occupancy       = occupancy;
endmodule

// File: tb/tb_mem_request_queue.sv
// Bench for mem_request_queue: directed scenarios with literal expectations
// plus randomized parser/scheduler traffic checked against a queue model.
module tb_mem_request_queue;
  import mem_request_queue_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_request_queue_if #(.QUEUE_DEPTH(DEPTH), .TIME_WIDTH(32)) bus ();

  mem_request_queue #(.QUEUE_DEPTH(DEPTH), .TIME_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain FIFO of entries plus a time counter
  queue_entry_t mq[$];
  logic [31:0]  m_time;

  always @(negedge clk) begin
    int  sz;
    bit  vin, can, epush;
    if (!rst_n) begin
      mq.delete();
      m_time = '0;
    end
    sz    = mq.size();
    vin   = bus.in.op_ready_s && (bus.in.opcode != NOP);
    can   = (sz < DEPTH) || (bus.head_pop && sz > 0);
    epush = vin && (bus.in.time_cpu <= m_time) && can;
    check("queue_time", 64'(bus.queue_time), 64'(m_time));
    check("occupancy", 64'(bus.occupancy), 64'(sz));
    check("queue_full", 64'(bus.queue_full), 64'(sz == DEPTH));
    check("head_valid", 64'(bus.head_valid), 64'(sz > 0));
    check("pending_request", 64'(bus.pending_request), 64'(vin && !epush));
    if (sz > 0) begin
      check("head_opcode", 64'(bus.head.opcode), 64'(mq[0].opcode));
      check("head_address", 64'(bus.head.address), 64'(mq[0].address));
      check("head_time_cpu", 64'(bus.head.time_cpu), 64'(mq[0].time_cpu));
      check("head_time_enq", 64'(bus.head.time_enq), 64'(mq[0].time_enq));
    end
    if (rst_n) begin
      if (bus.head_pop && sz > 0) void'(mq.pop_front());
      if (epush)
        mq.push_back('{opcode: bus.in.opcode, address: bus.in.address,
                       time_cpu: bus.in.time_cpu, time_enq: m_time});
      if (sz == 0 && vin && bus.in.time_cpu > m_time) m_time = bus.in.time_cpu;
      else                                            m_time = m_time + 32'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input parsed_op_t op, input logic [31:0] a,
                         input logic [31:0] t, input logic rdy);
    bus.in = '{opcode: op, address: a, time_cpu: t, op_ready_s: rdy};
  endtask

  int pop_pct[4] = '{10, 50, 90, 30};

  initial begin
    int  cnt;
    bit  adv;
    logic [31:0] base, t;
    int  r;
    bus.in       = '0;
    bus.head_pop = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) step();

    // Empty at t=0, request in the future: time skip then push
    set_req(READ, 32'h1234, 32'd5, 1'b1);
    rst_n = 1'b1;
    #1;
    check("t2_pending_before", 64'(bus.pending_request), 64'd1);
    check("t2_time_start", 64'(bus.queue_time), 64'd0);
    step();
    check("t2_time_skipped", 64'(bus.queue_time), 64'd5);
    check("t2_occ_before_push", 64'(bus.occupancy), 64'd0);
    check("t2_pending_at_push", 64'(bus.pending_request), 64'd0);
    step();
    set_req(NOP, '0, '0, 1'b0);
    #1;
    check("t2_occ", 64'(bus.occupancy), 64'd1);
    check("t2_head_valid", 64'(bus.head_valid), 64'd1);
    check("t2_head_addr", 64'(bus.head.address), 64'h1234);
    check("t2_head_enq", 64'(bus.head.time_enq), 64'd5);
    check("t2_time_after", 64'(bus.queue_time), 64'd6);

    // Pop the entry, then pop on empty
    bus.head_pop = 1'b1;
    step();
    check("t5_occ_after_pop", 64'(bus.occupancy), 64'd0);
    step();
    check("t5_occ_empty_pop", 64'(bus.occupancy), 64'd0);
    check("t5_head_valid", 64'(bus.head_valid), 64'd0);
    bus.head_pop = 1'b0;

    // NOP with ready: never pushed, no time skip
    set_req(NOP, 32'h55, 32'd1000, 1'b1);
    #1;
    check("t6_pending", 64'(bus.pending_request), 64'd0);
    step();
    check("t6_time", 64'(bus.queue_time), 64'd9);
    check("t6_occ", 64'(bus.occupancy), 64'd0);

    // Fill to 16, 17th waits, pop frees a slot on the same edge
    for (int i = 0; i < 16; i++) begin
      set_req((i % 2) ? WRITE : READ, 32'(i), 32'd0, 1'b1);
      step();
    end
    check("t3_full", 64'(bus.queue_full), 64'd1);
    check("t3_occ16", 64'(bus.occupancy), 64'd16);
    set_req(WRITE, 32'd16, 32'd0, 1'b1);
    #1;
    check("t3_pending_full", 64'(bus.pending_request), 64'd1);
    step();
    check("t3_pending_held", 64'(bus.pending_request), 64'd1);
    bus.head_pop = 1'b1;
    #1;
    check("t3_pending_with_pop", 64'(bus.pending_request), 64'd0);
    step();
    bus.head_pop = 1'b0;
    set_req(NOP, '0, '0, 1'b0);
    #1;
    check("t3_occ_after_swap", 64'(bus.occupancy), 64'd16);
    check("t3_head_addr", 64'(bus.head.address), 64'd1);

    // Drain to 5 entries, then reset mid-operation
    bus.head_pop = 1'b1;
    repeat (11) step();
    bus.head_pop = 1'b0;
    #1;
    check("t1_occ_before_reset", 64'(bus.occupancy), 64'd5);
    rst_n = 1'b0;
    #1;
    check("t1_occ", 64'(bus.occupancy), 64'd0);
    check("t1_head_valid", 64'(bus.head_valid), 64'd0);
    check("t1_time", 64'(bus.queue_time), 64'd0);
    check("t1_full", 64'(bus.queue_full), 64'd0);
    repeat (3) step();

    // One entry held, future request waits for the time base (no skip)
    set_req(READ, 32'hA0, 32'd0, 1'b1);
    rst_n = 1'b1;
    step();
    set_req(NOP, '0, '0, 1'b0);
    #1;
    check("t4_occ1", 64'(bus.occupancy), 64'd1);
    repeat (39) step();
    check("t4_time40", 64'(bus.queue_time), 64'd40);
    set_req(WRITE, 32'hB0, 32'd100, 1'b1);
    #1;
    cnt = 0;
    while (bus.pending_request && cnt < 200) begin
      cnt++;
      step();
    end
    check("t4_pending_cycles", 64'(cnt), 64'd60);
    check("t4_time_at_push", 64'(bus.queue_time), 64'd100);
    step();
    set_req(NOP, '0, '0, 1'b0);
    #1;
    check("t4_occ2", 64'(bus.occupancy), 64'd2);

    // Randomized parser and scheduler traffic
    adv = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (adv) begin
        r    = $urandom_range(0, 9);
        base = bus.queue_time;
        if ($urandom_range(0, 3) == 0) t = base + $urandom_range(1, 40);
        else                           t = base - $urandom_range(0, 3);
        if (r == 0)      set_req(READ, $urandom, t, 1'b0);
        else if (r == 1) set_req(NOP, $urandom, t, 1'b1);
        else             set_req((r < 6) ? READ : WRITE, $urandom, t, 1'b1);
      end
      bus.head_pop = ($urandom_range(0, 99) < pop_pct[cyc / 750]);
      #1;
      adv = !(bus.in.op_ready_s && bus.in.opcode != NOP) || !bus.pending_request;
      step();
    end

    bus.head_pop = 1'b0;
    set_req(NOP, '0, '0, 1'b0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
